// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmitter state encoding and the divider helper.
package uart_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // A programmed divider of zero would stall the line, so it runs as one.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, and the
// start/data/stop serialiser with a programmable bit period.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        sel,
  output logic        tx
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [3:0] sat_cnt(input logic [CNT_W-1:0] c);
    logic [31:0] w;
    w = 32'(c);
    return (w > 32'd15) ? 4'hF : w[3:0];
  endfunction

  logic [3:0]       offset;
  logic             wr_txdata;
  logic             wr_div;
  logic             rd_en;
  logic             stat_rd;
  logic             drop;
  logic [15:0]      div;
  logic             ovf;
  logic [31:0]      status;

  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic             tx_nxt;
  logic             load_cnt;
  logic             shift_en;
  logic             data_start;
  logic             bit_end;
  logic [15:0]      bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  logic             unused_bits;
  assign unused_bits = &{1'b0, mem_wdata[31:16], mem_wstrb[3:2]};

  assign sel       = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = mem_addr[3:0];
  assign wr_txdata = sel && (offset == OFF_TXDATA) && mem_wstrb[0];
  assign wr_div    = sel && (offset == OFF_BAUDDIV);
  assign rd_en     = sel && mem_rstrb;
  assign stat_rd   = rd_en && (offset == OFF_STATUS);
  assign drop      = wr_txdata && fifo_full && !fifo_pop;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_txdata),
    .push_data (mem_wdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    status                      = '0;
    status[STAT_BUSY]           = (state != S_IDLE);
    status[STAT_FULL]           = fifo_full;
    status[STAT_EMPTY]          = fifo_empty;
    status[STAT_OVF]            = ovf;
    status[STAT_CNT_LSB +: 4]   = sat_cnt(fifo_count);
  end

  // A drop on the same edge as a STATUS read leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= DIV_RESET;
      ovf       <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if (wr_div && mem_wstrb[0]) div[7:0]  <= mem_wdata[7:0];
      if (wr_div && mem_wstrb[1]) div[15:8] <= mem_wdata[15:8];
      if (drop)         ovf <= 1'b1;
      else if (stat_rd) ovf <= 1'b0;
      if (rd_en) begin
        case (offset)
          OFF_STATUS:  mem_rdata <= status;
          OFF_BAUDDIV: mem_rdata <= {16'h0, div};
          default:     mem_rdata <= '0;
        endcase
      end
    end
  end

  assign bit_end = (bit_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tx_nxt     = tx;
    fifo_pop   = 1'b0;
    load_cnt   = 1'b0;
    shift_en   = 1'b0;
    data_start = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load_cnt  = 1'b1;
          tx_nxt    = 1'b0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          load_cnt   = 1'b1;
          data_start = 1'b1;
          tx_nxt     = shreg[0];
          state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          load_cnt = 1'b1;
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = S_STOP;
          end else begin
            shift_en = 1'b1;
            tx_nxt   = shreg[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          tx_nxt    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The divider is sampled only at bit starts, so mid-frame writes wait a bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      tx <= tx_nxt;
      if (load_cnt)            bit_cnt <= eff_div(div) - 16'd1;
      else if (!bit_end)       bit_cnt <= bit_cnt - 16'd1;
      if (data_start)          bit_idx <= '0;
      else if (shift_en)       bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_pop)      shreg <= fifo_rdata;
    else if (shift_en) shreg <= {1'b0, shreg[7:1]};
  end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_4000, peripheral base address (16-byte aligned).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two).
REQ-003 SHALL have parameter DIV_RESET, default 16'd868, reset bit period in clk cycles.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mem_addr  input  32  CPU byte address.
REQ-007 SHALL have port mem_wdata  input  32  CPU write data.
REQ-008 SHALL have port mem_wstrb  input  4  CPU byte write strobes.
REQ-009 SHALL have port mem_rstrb  input  1  CPU read strobe.
REQ-010 SHALL have port mem_rdata  output  32  registered read data.
REQ-011 SHALL have port sel  output  1  combinational, high when mem_addr[31:4]==BASE_ADDR[31:4]; top level uses it to mux mem_rdata.
REQ-012 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-013 Register map (offset = mem_addr[3:0]): 0x0 TXDATA (W), 0x4 STATUS (R), 0x8 BAUDDIV (R/W); other offsets read 0, writes ignored.
REQ-014 TXDATA push SHALL occur only on a cycle with sel, offset 0x0 and mem_wstrb[0]=1, pushing mem_wdata[7:0]; wstrb[1..3] cycles at the same address SHALL NOT push (CPU stores strobe bytes in successive cycles).
REQ-015 Push while FIFO full SHALL drop the byte and set sticky overflow flag.
REQ-016 STATUS read value: bit0 tx_busy (FSM not IDLE), bit1 fifo_full, bit2 fifo_empty, bit3 overflow, bits[7:4] fifo count (saturating at 15), others 0.
REQ-017 A STATUS read (rstrb with sel, offset 0x4) SHALL clear overflow on the same edge mem_rdata is loaded; an overflow set on that same edge SHALL win.
REQ-018 BAUDDIV: 16-bit; wstrb[0] writes bits[7:0], wstrb[1] writes bits[15:8]; read returns {16'h0,BAUDDIV}; value 0 SHALL be treated as 1.
REQ-019 Read latency: mem_rdata SHALL update on the edge where mem_rstrb=1 and sel=1, and hold its value otherwise.
REQ-020 FSM states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty (pop same edge); START->DATA after one bit period; DATA shifts 8 bits LSB first, each one bit period, then ->STOP; STOP->IDLE after one bit period.
REQ-021 tx SHALL be registered: 1 in IDLE/STOP, 0 in START, current data bit in DATA.
REQ-022 Bit-period counter SHALL reload from BAUDDIV at every bit start; a BAUDDIV write mid-frame takes effect at the next bit boundary.
REQ-023 Latency: byte written into empty FIFO at edge N with FSM IDLE -> pop and tx=0 after edge N+1.
REQ-024 Back-to-back frames SHALL be separated by exactly one IDLE cycle of tx=1.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and succeed even when full before the edge.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.

Reset
REQ-027 On rst: tx=1, FSM=IDLE, FIFO empty, overflow=0, BAUDDIV=DIV_RESET, mem_rdata=0, bit counter=0.
REQ-028 rst mid-frame SHALL abort the frame; tx=1 after that edge; queued bytes discarded.

Structure
REQ-029 Package uart_pkg SHALL hold register offsets, STATUS bit positions and FSM state encoding.
REQ-030 FIFO SHALL be sub-module sync_fifo (push, pop, full, empty, count); FSM and register decode stay in uart_tx_mmio.

Verification
REQ-031 BAUDDIV=4, write 0x55 to TXDATA -> tx low 4 cycles starting edge N+1, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles.
REQ-032 Store word 0x000000A5 to 0x0 with wstrb 0001,0010,0100,1000 on 4 cycles -> exactly one push, one frame of 0xA5.
REQ-033 BAUDDIV=1000, write 9 bytes rapidly -> 8 queued or 7 + 1 in flight per timing, 9th dropped only if full; STATUS read shows bit3=1 when dropped, second read bit3=0.
REQ-034 Write 0x0 then read BAUDDIV -> returns 0; frame bits last 1 cycle each.
REQ-035 Two bytes queued, BAUDDIV=2 -> frames separated by one idle-high cycle; STATUS bit2=1 after both popped.
REQ-036 Assert rst during DATA bit 3 -> tx=1 next edge, STATUS reads 0x4, BAUDDIV reads 868.
